gelato_banked_register_file: RTL and testbench

GELATO_BANKED_REGISTER_FILE -- requirements
Module: gelato_banked_register_file

---
 rtl/gelato_banked_register_file.sv | 148 ++++++++++++++
 tb/tb_gelato_banked_register_file.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gelato_banked_register_file.sv
// Banked warp register file: REQ_NUM read channels with per-bank round-robin
// arbitration, one masked writeback port that always wins its bank, and
// registered responses one cycle after each grant.
module gelato_banked_register_file #(
    parameter int unsigned BANK_NUM = 4,
    parameter int unsigned WARP_NUM = 8,
    parameter int unsigned REG_NUM  = 32,
    parameter int unsigned DATA_W   = 1024,
    parameter int unsigned REQ_NUM  = 3,
    parameter int unsigned TAG_W    = 4,
    localparam int unsigned WARP_W   = $clog2(WARP_NUM),
    localparam int unsigned REG_W    = $clog2(REG_NUM),
    localparam int unsigned LANE_NUM = DATA_W / 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic [REQ_NUM-1:0]          req_valid,
    output logic [REQ_NUM-1:0]          req_ready,
    input  logic [REQ_NUM*WARP_W-1:0]   req_warp,
    input  logic [REQ_NUM*REG_W-1:0]    req_reg,
    input  logic [REQ_NUM*TAG_W-1:0]    req_tag,
    output logic [REQ_NUM-1:0]          rsp_valid,
    output logic [REQ_NUM*DATA_W-1:0]   rsp_data,
    output logic [REQ_NUM*TAG_W-1:0]    rsp_tag,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic [WARP_W-1:0]           wb_warp,
    input  logic [REG_W-1:0]            wb_reg,
    input  logic [DATA_W-1:0]           wb_data,
    input  logic [LANE_NUM-1:0]         wb_mask
);

    localparam int unsigned BANK_W    = $clog2(BANK_NUM);
    localparam int unsigned BANK_ROWS = WARP_NUM * REG_NUM / BANK_NUM;
    localparam int unsigned ROW_W     = $clog2(BANK_ROWS);
    localparam int unsigned PTR_W     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    // Skewing by warp spreads the same register of different warps across banks.
    function automatic logic [BANK_W-1:0] bank_of(input logic [WARP_W-1:0] w,
                                                  input logic [REG_W-1:0]  r);
        logic [REG_W-1:0] s;
        s = REG_W'(w) + r;
        return s[BANK_W-1:0];
    endfunction

    // {warp,reg} >> BANK_W == warp*(REG_NUM/BANK_NUM) + reg/BANK_NUM.
    function automatic logic [ROW_W-1:0] row_of(input logic [WARP_W-1:0] w,
                                                input logic [REG_W-1:0]  r);
        logic [WARP_W+REG_W-1:0] flat;
        flat = {w, r};
        return ROW_W'(flat >> BANK_W);
    endfunction

    logic [DATA_W-1:0]  mem [BANK_NUM][BANK_ROWS];
    logic [BANK_W-1:0]  req_bank [REQ_NUM];
    logic [ROW_W-1:0]   req_row  [REQ_NUM];
    logic [BANK_W-1:0]  wb_bank;
    logic [ROW_W-1:0]   wb_row;
    logic               wb_fire;
    logic [REQ_NUM-1:0] grant;
    logic [PTR_W-1:0]   ptr_q [BANK_NUM];
    logic [PTR_W-1:0]   ptr_d [BANK_NUM];
    logic [REQ_NUM-1:0]        rsp_valid_q;
    logic [REQ_NUM*DATA_W-1:0] rsp_data_q;
    logic [REQ_NUM*TAG_W-1:0]  rsp_tag_q;

    assign wb_ready  = rdy & ~rst;
    assign wb_fire   = wb_valid & wb_ready;
    assign wb_bank   = bank_of(wb_warp, wb_reg);
    assign wb_row    = row_of(wb_warp, wb_reg);
    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;

    // Decode each channel's address into bank and row.
    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            req_bank[i] = bank_of(req_warp[i*WARP_W +: WARP_W], req_reg[i*REG_W +: REG_W]);
            req_row[i]  = row_of(req_warp[i*WARP_W +: WARP_W], req_reg[i*REG_W +: REG_W]);
        end
    end

    // Per-bank round-robin: scan channels starting at the pointer, first requester wins.
    always_comb begin
        logic             found;
        logic             bank_open;
        logic [PTR_W:0]   cand;
        logic [REQ_NUM-1:0] hit;
        grant = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            ptr_d[b]  = ptr_q[b];
            found     = 1'b0;
            bank_open = rdy & ~rst & ~(wb_fire && wb_bank == BANK_W'(b));
            for (int i = 0; i < REQ_NUM; i++) begin
                hit[i] = bank_open & req_valid[i] & (req_bank[i] == BANK_W'(b));
            end
            for (int k = 0; k < REQ_NUM; k++) begin
                cand = {1'b0, ptr_q[b]} + (PTR_W+1)'(k);
                if (cand >= (PTR_W+1)'(REQ_NUM)) begin
                    cand = cand - (PTR_W+1)'(REQ_NUM);
                end
                for (int i = 0; i < REQ_NUM; i++) begin
                    if (!found && hit[i] && cand == (PTR_W+1)'(i)) begin
                        found    = 1'b1;
                        grant[i] = 1'b1;
                        ptr_d[b] = (i == REQ_NUM - 1) ? '0 : PTR_W'(i + 1);
                    end
                end
            end
        end
    end

    // Storage: masked per-lane writes, never cleared by reset.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANE_NUM; l++) begin
            if (wb_fire && wb_mask[l]) begin
                mem[wb_bank][wb_row][l*32 +: 32] <= wb_data[l*32 +: 32];
            end
        end
    end

    // Response registers and arbitration pointers; everything holds while rdy=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            for (int b = 0; b < BANK_NUM; b++) begin
                ptr_q[b] <= '0;
            end
        end else if (rdy) begin
            rsp_valid_q <= grant;
            for (int b = 0; b < BANK_NUM; b++) begin
                ptr_q[b] <= ptr_d[b];
            end
            for (int i = 0; i < REQ_NUM; i++) begin
                if (grant[i]) begin
                    // A granted bank is never the writeback bank, so this is the settled value.
                    rsp_data_q[i*DATA_W +: DATA_W] <= mem[req_bank[i]][req_row[i]];
                    rsp_tag_q[i*TAG_W +: TAG_W]    <= req_tag[i*TAG_W +: TAG_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_gelato_banked_register_file.sv
// Directed bench for gelato_banked_register_file with default parameters.
module tb_gelato_banked_register_file;

    localparam int unsigned REQ_NUM = 3;
    localparam int unsigned WARP_W  = 3;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned DATA_W  = 1024;
    localparam int unsigned LANES   = 32;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        rdy;
    logic [REQ_NUM-1:0]          req_valid;
    logic [REQ_NUM-1:0]          req_ready;
    logic [REQ_NUM*WARP_W-1:0]   req_warp;
    logic [REQ_NUM*REG_W-1:0]    req_reg;
    logic [REQ_NUM*TAG_W-1:0]    req_tag;
    logic [REQ_NUM-1:0]          rsp_valid;
    logic [REQ_NUM*DATA_W-1:0]   rsp_data;
    logic [REQ_NUM*TAG_W-1:0]    rsp_tag;
    logic                        wb_valid;
    logic                        wb_ready;
    logic [WARP_W-1:0]           wb_warp;
    logic [REG_W-1:0]            wb_reg;
    logic [DATA_W-1:0]           wb_data;
    logic [LANES-1:0]            wb_mask;

    int total = 0;
    int bad   = 0;

    gelato_banked_register_file dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_warp  (req_warp),
        .req_reg   (req_reg),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_warp   (wb_warp),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .wb_mask   (wb_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic v, input logic [WARP_W-1:0] w,
                           input logic [REG_W-1:0] r, input logic [TAG_W-1:0] t);
        req_valid[ch]                = v;
        req_warp[ch*WARP_W +: WARP_W] = w;
        req_reg[ch*REG_W +: REG_W]    = r;
        req_tag[ch*TAG_W +: TAG_W]    = t;
    endtask

    task automatic set_wb(input logic v, input logic [WARP_W-1:0] w, input logic [REG_W-1:0] r,
                          input logic [DATA_W-1:0] d, input logic [LANES-1:0] m);
        wb_valid = v;
        wb_warp  = w;
        wb_reg   = r;
        wb_data  = d;
        wb_mask  = m;
    endtask

    function automatic logic [DATA_W-1:0] rd(input int ch);
        return rsp_data[ch*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] tg(input int ch);
        return DATA_W'(rsp_tag[ch*TAG_W +: TAG_W]);
    endfunction

    function automatic logic [DATA_W-1:0] fill(input logic [31:0] w);
        return {LANES{w}};
    endfunction

    initial begin
        logic [DATA_W-1:0] partial;
        logic [DATA_W-1:0] zero;
        zero = '0;
        rst = 1'b1;
        rdy = 1'b1;
        req_valid = '0; req_warp = '0; req_reg = '0; req_tag = '0;
        set_wb(1'b0, '0, '0, '0, '0);

        // Reset: outputs cleared, nothing granted even with a valid request.
        #1;
        set_req(0, 1'b1, 3'd0, 5'd0, 4'd1);
        wb_valid = 1'b1;
        #1;
        chk("rst_req_ready", DATA_W'(req_ready), DATA_W'(3'b000));
        chk("rst_wb_ready", DATA_W'(wb_ready), DATA_W'(1'b0));
        tick();
        tick();
        chk("rst_rsp_valid", DATA_W'(rsp_valid), DATA_W'(3'b000));
        chk("rst_rsp_tag", DATA_W'(rsp_tag), DATA_W'(0));
        chk("rst_rsp_data", rsp_data[DATA_W-1:0], zero);
        req_valid = '0;
        wb_valid  = 1'b0;
        rst = 1'b0;

        // Full write warp1 reg2, then read it back on ch0.
        set_wb(1'b1, 3'd1, 5'd2, fill(32'hA5A5A5A5), '1);
        #1;
        chk("wb_ready", DATA_W'(wb_ready), DATA_W'(1'b1));
        tick();
        wb_valid = 1'b0;
        set_req(0, 1'b1, 3'd1, 5'd2, 4'd3);
        #1;
        chk("raw_ready", DATA_W'(req_ready), DATA_W'(3'b001));
        tick();
        req_valid = '0;
        chk("raw_rsp_valid", DATA_W'(rsp_valid), DATA_W'(3'b001));
        chk("raw_rsp_tag", tg(0), DATA_W'(4'd3));
        chk("raw_rsp_data", rd(0), fill(32'hA5A5A5A5));

        // Lane-0-only write; other lanes carry junk that must be ignored.
        set_wb(1'b1, 3'd1, 5'd2, {fill(32'hDEADBEEF)} ^ {{(LANES-1){32'h0}}, 32'hDEADBEEE}, 32'h1);
        tick();
        wb_valid = 1'b0;
        set_req(1, 1'b1, 3'd1, 5'd2, 4'd5);
        #1;
        chk("mask_ready", DATA_W'(req_ready), DATA_W'(3'b010));
        tick();
        req_valid = '0;
        partial = {{(LANES-1){32'hA5A5A5A5}}, 32'h00000001};
        chk("mask_rsp_valid", DATA_W'(rsp_valid), DATA_W'(3'b010));
        chk("mask_rsp_data", rd(1), partial);

        // Seed warp0 regs 0,1,2,4.
        set_wb(1'b1, 3'd0, 5'd0, fill(32'h11111111), '1); tick();
        set_wb(1'b1, 3'd0, 5'd1, fill(32'h22222222), '1); tick();
        set_wb(1'b1, 3'd0, 5'd2, fill(32'h33333333), '1); tick();
        set_wb(1'b1, 3'd0, 5'd4, fill(32'h44444444), '1); tick();
        wb_valid = 1'b0;

        // Three channels to banks 0,1,2 in one cycle.
        set_req(0, 1'b1, 3'd0, 5'd0, 4'd1);
        set_req(1, 1'b1, 3'd0, 5'd1, 4'd2);
        set_req(2, 1'b1, 3'd0, 5'd2, 4'd6);
        #1;
        chk("par_ready", DATA_W'(req_ready), DATA_W'(3'b111));
        tick();
        req_valid = '0;
        chk("par_rsp_valid", DATA_W'(rsp_valid), DATA_W'(3'b111));
        chk("par_data0", rd(0), fill(32'h11111111));
        chk("par_data1", rd(1), fill(32'h22222222));
        chk("par_data2", rd(2), fill(32'h33333333));
        chk("par_tag2", tg(2), DATA_W'(4'd6));
        #1;
        chk("idle_ready", DATA_W'(req_ready), DATA_W'(3'b000));

        // Reset pointers, then all channels contend for bank0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 3'd0, 5'd0, 4'd7);
        set_req(1, 1'b1, 3'd0, 5'd0, 4'd8);
        set_req(2, 1'b1, 3'd0, 5'd0, 4'd9);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("rr_ready%0d", c), DATA_W'(req_ready), DATA_W'(3'b001 << (c % 3)));
            tick();
            chk($sformatf("rr_rsp%0d", c), DATA_W'(rsp_valid), DATA_W'(3'b001 << (c % 3)));
            chk($sformatf("rr_tag%0d", c), tg(c % 3), DATA_W'(7 + (c % 3)));
        end
        chk("rr_data", rd(2), fill(32'h11111111));
        req_valid = '0;

        // Writeback to bank0 blocks ch0; ch1 on bank1 still proceeds.
        set_wb(1'b1, 3'd0, 5'd4, fill(32'h55555555), '1);
        set_req(0, 1'b1, 3'd0, 5'd0, 4'd10);
        set_req(1, 1'b1, 3'd0, 5'd1, 4'd4);
        #1;
        chk("wbprio_ready", DATA_W'(req_ready), DATA_W'(3'b010));
        tick();
        wb_valid = 1'b0;
        req_valid[1] = 1'b0;
        chk("wbprio_rsp", DATA_W'(rsp_valid), DATA_W'(3'b010));
        #1;
        chk("wbprio_retry", DATA_W'(req_ready), DATA_W'(3'b001));
        tick();
        req_valid = '0;
        chk("retry_rsp", DATA_W'(rsp_valid), DATA_W'(3'b001));
        chk("retry_tag", tg(0), DATA_W'(4'd10));
        chk("retry_data", rd(0), fill(32'h11111111));

        // rdy=0: no grant, writeback ignored, responses held.
        rdy = 1'b0;
        set_req(2, 1'b1, 3'd0, 5'd4, 4'd11);
        set_wb(1'b1, 3'd0, 5'd4, fill(32'h66666666), '1);
        #1;
        chk("stall_ready", DATA_W'(req_ready), DATA_W'(3'b000));
        chk("stall_wb_ready", DATA_W'(wb_ready), DATA_W'(1'b0));
        tick();
        wb_valid = 1'b0;
        chk("stall_rsp_hold", DATA_W'(rsp_valid), DATA_W'(3'b001));
        chk("stall_tag_hold", tg(0), DATA_W'(4'd10));
        chk("stall_data_hold", rd(0), fill(32'h11111111));
        rdy = 1'b1;
        #1;
        chk("resume_ready", DATA_W'(req_ready), DATA_W'(3'b100));
        tick();
        req_valid = '0;
        chk("resume_rsp", DATA_W'(rsp_valid), DATA_W'(3'b100));
        chk("resume_data", rd(2), fill(32'h55555555));
        chk("resume_tag", tg(2), DATA_W'(4'd11));

        // Reset drops a response that rdy=0 was holding.
        set_req(0, 1'b1, 3'd0, 5'd1, 4'd12);
        tick();
        req_valid = '0;
        chk("inflight_rsp", DATA_W'(rsp_valid), DATA_W'(3'b001));
        rdy = 1'b0;
        rst = 1'b1;
        tick();
        chk("drop_rsp_valid", DATA_W'(rsp_valid), DATA_W'(3'b000));
        chk("drop_rsp_tag", DATA_W'(rsp_tag), DATA_W'(0));
        rst = 1'b0;
        rdy = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
